// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM port between the fetch (I) and load/store (D) requesters.
// Optional I-side starvation guard enabled by defining RAM_ARB_STARVE_GUARD_EN.
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  logic   resp_valid;
  owner_t resp_owner;
  logic   i_pri;
  logic   read_issued;

  if (STARVE_LIMIT == 0) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign i_pri = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts consecutive denied I-side cycles, saturating at the limit.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      starve_cnt <= '0;
    end else if (i_req && !i_gnt) begin
      if (starve_cnt != CNT_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end
`else
  assign i_pri = 1'b0;
`endif

  // Same-cycle arbitration and RAM drive from the winner.
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    d_gnt     = d_req & ~(i_req & i_pri);
    i_gnt     = i_req & (~d_req | i_pri);
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr;
    end
  end

  assign mem_en      = i_gnt | d_gnt;
  assign read_issued = i_gnt | (d_gnt & ~d_we);

  // Remembers who owns the read whose data returns next cycle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      resp_valid <= 1'b0;
      resp_owner <= OWNER_I;
    end else begin
      resp_valid <= read_issued;
      if (read_issued) resp_owner <= d_gnt ? OWNER_D : OWNER_I;
    end
  end

  assign i_rvalid = resp_valid & (resp_owner == OWNER_I);
  assign d_rvalid = resp_valid & (resp_owner == OWNER_D);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural arbitration/memory model.
module tb_ram_port_arbiter;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int LIMIT = 4;

  logic          clk;
  logic          n_reset;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_checks;
  int n_errors;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .n_reset(n_reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM attached to the port.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Behavioural reference: arbitration rules, expected memory contents, pending response.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_cnt;
  logic          m_pend;
  logic          m_owner_d;
  logic [DW-1:0] m_pend_data;
  logic          eg_i, eg_d;

  function automatic logic model_flip();
`ifdef RAM_ARB_STARVE_GUARD_EN
    return (m_cnt >= LIMIT) && i_req && d_req;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_i_gnt();
    return i_req && (!d_req || model_flip());
  endfunction

  function automatic logic exp_d_gnt();
    return d_req && !model_flip();
  endfunction

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_pend    <= 1'b0;
      m_owner_d <= 1'b0;
      m_cnt     <= 0;
    end else begin
      eg_i = exp_i_gnt();
      eg_d = exp_d_gnt();
      m_pend      <= eg_i || (eg_d && !d_we);
      m_owner_d   <= eg_d;
      m_pend_data <= eg_d ? ref_mem[d_addr] : ref_mem[i_addr];
      if (eg_d && d_we) ref_mem[d_addr] <= d_wdata;
      if (i_req && !eg_i) m_cnt <= (m_cnt < LIMIT) ? m_cnt + 1 : m_cnt;
      else                m_cnt <= 0;
    end
  end

  task automatic drive_idle();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic dwrite(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(posedge clk); #1;
    drive_idle();
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = v;
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (i_rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_i_rvalid: got %b want 0", i_rvalid); end
    n_checks++; if (d_rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_d_rvalid: got %b want 0", d_rvalid); end
    n_reset = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL rel_mem_en: got %b want 0", mem_en); end
    n_checks++; if (i_gnt !== 1'b0 || d_gnt !== 1'b0) begin n_errors++; $display("FAIL rel_gnts: got i=%b d=%b want 0 0", i_gnt, d_gnt); end
    n_checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_errors++; $display("FAIL rel_rvalid: got i=%b d=%b want 0 0", i_rvalid, d_rvalid); end
  endtask

  task automatic test_i_read();
    dwrite(14'h010, 32'hDEADBEEF);
    i_req = 1'b1; i_addr = 14'h010;
    @(negedge clk);
    n_checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_errors++; $display("FAIL iread_gnt: got i=%b d=%b want 1 0", i_gnt, d_gnt); end
    n_checks++; if (mem_addr !== 14'h010 || mem_we !== 1'b0) begin n_errors++; $display("FAIL iread_addr: got %h we=%b want 010 0", mem_addr, mem_we); end
    n_checks++; if (d_rvalid !== 1'b0) begin n_errors++; $display("FAIL write_no_rvalid: got %b want 0", d_rvalid); end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_checks++; if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin n_errors++; $display("FAIL iread_rvalid: got i=%b d=%b want 1 0", i_rvalid, d_rvalid); end
    n_checks++; if (i_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL iread_data: got %h want deadbeef", i_rdata); end
  endtask

  task automatic test_contention();
    dwrite(14'h020, 32'hA5A55A5A);
    dwrite(14'h044, 32'h0BADF00D);
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 14'h044;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h020;
    @(negedge clk);
    n_checks++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin n_errors++; $display("FAIL cont_gnt: got d=%b i=%b want 1 0", d_gnt, i_gnt); end
    n_checks++; if (mem_addr !== 14'h020) begin n_errors++; $display("FAIL cont_addr: got %h want 020", mem_addr); end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA5A55A5A) begin n_errors++; $display("FAIL cont_d_ret: got v=%b %h want 1 a5a55a5a", d_rvalid, d_rdata); end
    n_checks++; if (i_rdata !== 32'h0) begin n_errors++; $display("FAIL cont_nonowner: got %h want 0", i_rdata); end
    n_checks++; if (i_gnt !== 1'b1 || mem_addr !== 14'h044) begin n_errors++; $display("FAIL cont_i_held: got g=%b %h want 1 044", i_gnt, mem_addr); end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h0BADF00D || d_rvalid !== 1'b0) begin n_errors++; $display("FAIL cont_i_ret: got v=%b %h dv=%b want 1 0badf00d 0", i_rvalid, i_rdata, d_rvalid); end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 14'h030; d_wdata = 32'h12345678;
    @(negedge clk);
    n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h12345678 || mem_addr !== 14'h030) begin n_errors++; $display("FAIL wr_drive: got we=%b %h @%h want 1 12345678 @030", mem_we, mem_wdata, mem_addr); end
    @(posedge clk); #1;
    d_we = 1'b0; d_wdata = '0;
    @(negedge clk);
    n_checks++; if (d_rvalid !== 1'b0 || mem_we !== 1'b0 || d_gnt !== 1'b1) begin n_errors++; $display("FAIL wr_then_rd: got rv=%b we=%b g=%b want 0 0 1", d_rvalid, mem_we, d_gnt); end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678) begin n_errors++; $display("FAIL rd_after_wr: got v=%b %h want 1 12345678", d_rvalid, d_rdata); end
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 14'h010;
    @(negedge clk);
    n_checks++; if (i_gnt !== 1'b1) begin n_errors++; $display("FAIL mid_gnt: got %b want 1", i_gnt); end
    #2;
    n_reset = 1'b0;
    drive_idle();
    @(posedge clk); @(negedge clk);
    n_checks++; if (i_rvalid !== 1'b0) begin n_errors++; $display("FAIL mid_in_reset: got %b want 0", i_rvalid); end
    @(posedge clk); @(negedge clk);
    n_reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_errors++; $display("FAIL mid_after_rel%0d: got i=%b d=%b want 0 0", k, i_rvalid, d_rvalid); end
    end
  endtask

  task automatic test_starve();
    logic want_i;
    @(posedge clk); #1;
    drive_idle();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 14'h010;
      d_req = 1'b1; d_we = 1'b0; d_addr = 14'h030;
      @(negedge clk);
`ifdef RAM_ARB_STARVE_GUARD_EN
      want_i = ((k % (LIMIT + 1)) == LIMIT);
`else
      want_i = 1'b0;
`endif
      n_checks++; if (i_gnt !== want_i || d_gnt !== !want_i) begin n_errors++; $display("FAIL starve_%0d: got i=%b d=%b want %b %b", k, i_gnt, d_gnt, want_i, !want_i); end
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_random();
    logic last_ig, last_dg;
    logic ei, ed;
    logic [AW-1:0] ea;
    for (int a = 0; a < 16; a++) dwrite(AW'(a), DW'($urandom));
    last_ig = 1'b0; last_dg = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (!(i_req && !last_ig && $urandom_range(9) != 0)) begin
        i_req  = 1'($urandom_range(1));
        i_addr = AW'($urandom_range(15));
      end
      if (!(d_req && !last_dg && $urandom_range(9) != 0)) begin
        d_req   = 1'($urandom_range(1));
        d_we    = 1'($urandom_range(1));
        d_addr  = AW'($urandom_range(15));
        d_wdata = DW'($urandom);
      end
      @(negedge clk);
      ei = exp_i_gnt();
      ed = exp_d_gnt();
      ea = ed ? d_addr : (ei ? i_addr : '0);
      n_checks++; if (i_gnt !== ei || d_gnt !== ed) begin n_errors++; $display("FAIL rnd_gnt@%0d: got i=%b d=%b want %b %b", n, i_gnt, d_gnt, ei, ed); end
      n_checks++; if (mem_en !== (ei | ed) || mem_we !== (ed & d_we)) begin n_errors++; $display("FAIL rnd_en_we@%0d: got %b %b want %b %b", n, mem_en, mem_we, ei | ed, ed & d_we); end
      n_checks++; if (mem_addr !== ea || mem_wdata !== (ed ? d_wdata : '0)) begin n_errors++; $display("FAIL rnd_addr_data@%0d: got %h %h want %h %h", n, mem_addr, mem_wdata, ea, ed ? d_wdata : '0); end
      n_checks++; if (i_rvalid !== (m_pend & !m_owner_d) || d_rvalid !== (m_pend & m_owner_d)) begin n_errors++; $display("FAIL rnd_rvalid@%0d: got i=%b d=%b want %b %b", n, i_rvalid, d_rvalid, m_pend & !m_owner_d, m_pend & m_owner_d); end
      if (m_pend) begin
        n_checks++;
        if ((m_owner_d ? d_rdata : i_rdata) !== m_pend_data || (m_owner_d ? i_rdata : d_rdata) !== '0) begin
          n_errors++; $display("FAIL rnd_rdata@%0d: got i=%h d=%h want owner_d=%b data %h", n, i_rdata, d_rdata, m_owner_d, m_pend_data);
        end
      end
      last_ig = ei;
      last_dg = ed;
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_reset  = 1'b0;
    drive_idle();
    test_reset();
    test_i_read();
    test_contention();
    test_write_read();
    test_reset_mid_read();
    test_starve();
    test_random();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single synchronous instruction/data RAM port between two requesters: the fetch stage (I side) and the load/store unit (D side).
- Arbitrates every cycle and drives the RAM port from the winner.
- Tracks which requester owns the outstanding read and routes the returned read data back to it with a valid strobe.
- Sits between the CPU pipeline and the RAM; it replaces direct fetch-stage ownership of the port.

Parameters:
- ADDR_WIDTH, 14, word-address width of the RAM port.
- DATA_WIDTH, 32, data width of the RAM port.
- STARVE_LIMIT, 4, consecutive denied I-side cycles before the I side is forced a grant (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- n_reset  in  1  asynchronous active-low reset.
- i_req  in  1  fetch read request.
- i_addr  in  ADDR_WIDTH  fetch word address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  i_rdata valid this cycle.
- i_rdata  out  DATA_WIDTH  fetch read data.
- d_req  in  1  load/store request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  load/store word address.
- d_wdata  in  DATA_WIDTH  store data.
- d_gnt  out  1  load/store request accepted this cycle.
- d_rvalid  out  1  d_rdata valid this cycle (reads only).
- d_rdata  out  DATA_WIDTH  load read data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM word address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data; valid on the cycle after an enabled read.

Behaviour:
- Clocking and reset: one clock (clk). Reset n_reset is asynchronous and active-low.
- Reset state: resp_valid=0, resp_owner=I, starve_cnt=0.
  - Registered outputs i_rvalid and d_rvalid are 0 during reset.
  - Combinational outputs follow the inputs during reset. i_gnt, d_gnt and mem_en may assert, but no owner or response state is updated while reset is asserted.
- Arbitration (combinational, same cycle):
  - Only d_req: d_gnt=1.
  - Only i_req: i_gnt=1.
  - Both: d_gnt=1, i_gnt=0 (D priority), except as modified by the Optional Feature.
  - Neither: both grants 0.
- Handshake:
  - A transfer occurs when req and gnt are both 1 in the same cycle.
  - A requester holds req, addr, we and wdata stable until it sees gnt.
  - req may drop without a grant; nothing is issued in that case.
- RAM drive (combinational from the winner):
  - mem_en = i_gnt | d_gnt.
  - mem_we = d_gnt & d_we.
  - mem_addr and mem_wdata come from the winner.
  - I grants force mem_we=0.
  - When idle: mem_we=0, mem_addr=0, mem_wdata=0.
- Response tracking:
  - On a granted read at edge N: resp_valid<=1, resp_owner<=winner.
  - On any other cycle (idle or write): resp_valid<=0.
- Read latency: exactly 1 cycle after the grant.
  - In cycle N+1: X_rvalid = resp_valid & (resp_owner==X).
  - X_rdata = mem_rdata, passed combinationally.
  - The non-owner's rdata is held at 0.
- Writes produce no rvalid.
- Back-to-back operation:
  - A new grant is allowed every cycle, including the cycle in which the previous read's data returns. Throughput is 1 access per cycle.
  - A write followed by a read to the same address in the next cycle returns the written data (RAM write-first semantics are not required of this block).
- Reset mid-read: a pending response is discarded. No rvalid is produced after reset release for a read granted before reset.
- No internal FSM beyond the resp_valid/resp_owner pair; starve_cnt exists only with the feature.

Optional Feature:
- Macro: RAM_ARB_STARVE_GUARD_EN.
- Defined:
  - starve_cnt, width $clog2(STARVE_LIMIT+1), increments each cycle in which i_req=1 and i_gnt=0.
  - It clears to 0 on any cycle with i_req=0 or i_gnt=1.
  - When starve_cnt==STARVE_LIMIT and both requests are present, priority flips: i_gnt=1, d_gnt=0. The counter clears on that grant.
  - starve_cnt saturates at STARVE_LIMIT.
- Undefined: strict D priority; the I side can be starved indefinitely; no counter logic.

Test Plan:
- Reset with n_reset=0 for 3 cycles, then release with no requests -> i_rvalid=d_rvalid=0 and mem_en=0; i_gnt=d_gnt=0.
- i_req=1, i_addr=0x010, RAM holds 0xDEADBEEF at 0x010 -> i_gnt=1 and mem_addr=0x010 same cycle; next cycle i_rvalid=1, i_rdata=0xDEADBEEF, d_rvalid=0.
- i_req and d_req (read, d_addr=0x020) in the same cycle -> d_gnt=1, i_gnt=0, mem_addr=0x020; next cycle d_rvalid=1 and i_gnt=1 with mem_addr=i_addr (fetch held).
- d write 0x12345678 to 0x030, then a D read of 0x030 on the next cycle -> mem_we=1 on the first cycle, d_rvalid=0 on the second cycle, d_rvalid=1 with d_rdata=0x12345678 on the third cycle.
- I read granted, then n_reset pulsed low before the return cycle -> no i_rvalid after release; resp_valid=0.
- With RAM_ARB_STARVE_GUARD_EN and STARVE_LIMIT=4, hold both requests continuously -> D granted 4 cycles, I granted on the 5th, pattern repeats; without the macro, D is granted every cycle.
